// File: rtl/arb_pkg.sv
// Shared types and constants for the 4-requester round-robin arbiter.
package arb_pkg;

  localparam int unsigned ARB_N = 4;
  localparam int unsigned ID_W  = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  function automatic logic [ARB_N-1:0] id2onehot(input logic [ID_W-1:0] id);
    return 4'b0001 << id;
  endfunction

endpackage

// File: rtl/rr_pick_4.sv
// Combinational 4:2 pick. Priority starts at last_id-1 and wraps, so last_id is served last.
module rr_pick_4
  import arb_pkg::*;
(
  input  logic [ARB_N-1:0] req,
  input  logic [ARB_N-1:0] mask,
  input  logic [ID_W-1:0]  last_id,
  input  logic             rr_en,
  output logic             any,
  output logic [ID_W-1:0]  id
);

  logic [ARB_N-1:0] eff;
  logic [ARB_N-1:0] rot;
  logic [ID_W-1:0]  base;
  logic [ID_W-1:0]  ofs;

  always_comb begin
    eff  = req & ~mask;
    base = rr_en ? last_id : '0;
    // rot[3] is the highest-priority candidate (base-1), rot[0] the lowest (base)
    for (int k = 0; k < ARB_N; k++) begin
      rot[ARB_N-1-k] = eff[base - ID_W'(k) - ID_W'(1)];
    end
    any = 1'b1;
    ofs = '0;
    casez (rot)
      4'b1???: ofs = 2'd0;
      4'b01??: ofs = 2'd1;
      4'b001?: ofs = 2'd2;
      4'b0001: ofs = 2'd3;
      default: any = 1'b0;
    endcase
    id = base - ofs - ID_W'(1);
  end

endmodule

// File: rtl/rr_arbiter_4.sv
// Four-requester arbiter: rotating or fixed priority, grant held until release,
// with an optional hold timeout that preempts the owner when others wait.
module rr_arbiter_4
  import arb_pkg::*;
#(
  parameter bit          RR_EN    = 1'b1,
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ARB_N-1:0] req,
  output logic [ARB_N-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             gnt_valid,
  output logic             preempt
);

  localparam bit             TimeoutEn = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HoldLast = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  arb_state_e       state_q, state_d;
  logic [ARB_N-1:0] gnt_q, gnt_d;
  logic [ID_W-1:0]  gnt_id_q, gnt_id_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic             preempt_q, preempt_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [ID_W-1:0]  last_id_q, last_id_d;

  logic             in_grant;
  logic [ARB_N-1:0] pick_mask;
  logic [ID_W-1:0]  pick_last;
  logic             pick_any;
  logic [ID_W-1:0]  pick_id;
  logic             timeout;

  // While granted, the owner is excluded and treated as the last owner for the next pick
  assign in_grant  = (state_q == GRANT);
  assign pick_mask = in_grant ? id2onehot(gnt_id_q) : '0;
  assign pick_last = in_grant ? gnt_id_q : last_id_q;
  assign timeout   = TimeoutEn && (hold_q == HoldLast);

  rr_pick_4 u_pick (
    .req     (req),
    .mask    (pick_mask),
    .last_id (pick_last),
    .rr_en   (RR_EN),
    .any     (pick_any),
    .id      (pick_id)
  );

  always_comb begin
    state_d     = state_q;
    gnt_id_d    = gnt_id_q;
    gnt_valid_d = gnt_valid_q;
    preempt_d   = 1'b0;
    hold_d      = hold_q;
    last_id_d   = last_id_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d     = GRANT;
          gnt_id_d    = pick_id;
          gnt_valid_d = 1'b1;
          hold_d      = '0;
        end
      end
      GRANT: begin
        if (!req[gnt_id_q]) begin
          // Release wins over a coincident timeout
          last_id_d = gnt_id_q;
          hold_d    = '0;
          if (pick_any) begin
            gnt_id_d = pick_id;
          end else begin
            state_d     = IDLE;
            gnt_valid_d = 1'b0;
          end
        end else if (timeout && pick_any) begin
          preempt_d = 1'b1;
          last_id_d = gnt_id_q;
          gnt_id_d  = pick_id;
          hold_d    = '0;
        end else if (!timeout) begin
          hold_d = hold_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    gnt_d = gnt_valid_d ? id2onehot(gnt_id_d) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gnt_id_q    <= '0;
      gnt_valid_q <= 1'b0;
      preempt_q   <= 1'b0;
      hold_q      <= '0;
      last_id_q   <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      gnt_valid_q <= gnt_valid_d;
      preempt_q   <= preempt_d;
      hold_q      <= hold_d;
      last_id_q   <= last_id_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = gnt_valid_q;
  assign preempt   = preempt_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed bench: rotating instance (MAX_HOLD=4) and fixed-priority instance (no timeout).
module tb_rr_arbiter_4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req_a = '0, req_b = '0;
  logic [3:0] gnt_a, gnt_b;
  logic [1:0] gnt_id_a, gnt_id_b;
  logic       gnt_valid_a, gnt_valid_b, preempt_a, preempt_b;
  int         n_checks = 0;
  int         n_pass = 0;

  always #5 clk = ~clk;

  rr_arbiter_4 #(.RR_EN(1'b1), .MAX_HOLD(4), .CNT_W(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req_a), .gnt(gnt_a), .gnt_id(gnt_id_a),
    .gnt_valid(gnt_valid_a), .preempt(preempt_a)
  );

  rr_arbiter_4 #(.RR_EN(1'b0), .MAX_HOLD(0), .CNT_W(5)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req_b), .gnt(gnt_b), .gnt_id(gnt_id_b),
    .gnt_valid(gnt_valid_b), .preempt(preempt_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    req_a = 4'b1111;
    step();
    step();
    n_checks++;
    if ({gnt_a, gnt_id_a, gnt_valid_a, preempt_a} !== 8'h00) begin
      $display("FAIL reset_a: got %b, expected 00000000",
               {gnt_a, gnt_id_a, gnt_valid_a, preempt_a});
    end else n_pass++;
    n_checks++;
    if ({gnt_b, gnt_id_b, gnt_valid_b, preempt_b} !== 8'h00) begin
      $display("FAIL reset_b: got %b, expected 00000000",
               {gnt_b, gnt_id_b, gnt_valid_b, preempt_b});
    end else n_pass++;
    rst_n = 1'b1;
    step();
    n_checks++;
    if ({gnt_a, gnt_id_a, gnt_valid_a, preempt_a} !== {4'b1000, 2'd3, 1'b1, 1'b0}) begin
      $display("FAIL first_grant: got %b, expected 10001110",
               {gnt_a, gnt_id_a, gnt_valid_a, preempt_a});
    end else n_pass++;
  endtask

  task automatic test_rr_rotation();
    int         exp_ids[4] = '{2, 1, 0, 3};
    int         cur = 3;
    logic [3:0] e_gnt;
    for (int i = 0; i < 4; i++) begin
      req_a = 4'b1111 & ~(4'b0001 << cur);
      step();
      e_gnt = 4'b0001 << exp_ids[i];
      n_checks++;
      if ({gnt_a, gnt_id_a, gnt_valid_a} !== {e_gnt, 2'(exp_ids[i]), 1'b1}) begin
        $display("FAIL rr_handoff_%0d: got gnt=%b id=%0d valid=%b, expected gnt=%b id=%0d valid=1",
                 i, gnt_a, gnt_id_a, gnt_valid_a, e_gnt, exp_ids[i]);
      end else n_pass++;
      cur = exp_ids[i];
    end
    req_a = 4'b0000;
    step();
    n_checks++;
    if ({gnt_a, gnt_valid_a, preempt_a} !== 6'b000000) begin
      $display("FAIL rr_idle: got gnt=%b valid=%b preempt=%b, expected 0000 0 0",
               gnt_a, gnt_valid_a, preempt_a);
    end else n_pass++;
  endtask

  task automatic test_fixed_priority();
    for (int r = 0; r < 2; r++) begin
      req_a = 4'b0010;
      req_b = 4'b0010;
      step();
      n_checks++;
      if ({gnt_b, gnt_id_b} !== {4'b0010, 2'd1}) begin
        $display("FAIL fixed_owner1_%0d: got gnt=%b id=%0d, expected 0010 id=1", r, gnt_b, gnt_id_b);
      end else n_pass++;
      req_a = 4'b0101;
      req_b = 4'b0101;
      step();
      n_checks++;
      if ({gnt_b, gnt_id_b, gnt_valid_b} !== {4'b0100, 2'd2, 1'b1}) begin
        $display("FAIL fixed_pick2_%0d: got gnt=%b id=%0d, expected 0100 id=2", r, gnt_b, gnt_id_b);
      end else n_pass++;
      // Rotating instance had owner 1, so requester 0 comes first
      if (r == 0) begin
        n_checks++;
        if ({gnt_a, gnt_id_a} !== {4'b0001, 2'd0}) begin
          $display("FAIL rr_after1: got gnt=%b id=%0d, expected 0001 id=0", gnt_a, gnt_id_a);
        end else n_pass++;
        req_a = 4'b0000;
      end
      if (r == 0) begin
        req_b = 4'b0000;
        step();
      end
    end
    for (int i = 0; i < 20; i++) begin
      step();
      n_checks++;
      if ({gnt_b, preempt_b} !== {4'b0100, 1'b0}) begin
        $display("FAIL fixed_no_timeout_%0d: got gnt=%b preempt=%b, expected 0100 0",
                 i, gnt_b, preempt_b);
      end else n_pass++;
    end
    req_b = 4'b0001;
    step();
    n_checks++;
    if ({gnt_b, gnt_id_b} !== {4'b0001, 2'd0}) begin
      $display("FAIL fixed_handoff0: got gnt=%b id=%0d, expected 0001 id=0", gnt_b, gnt_id_b);
    end else n_pass++;
    req_b = 4'b0000;
    step();
  endtask

  task automatic test_timeout();
    req_a = 4'b0001;
    step();
    req_a = 4'b0101;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if ({gnt_a, preempt_a} !== {4'b0001, 1'b0}) begin
        $display("FAIL hold_%0d: got gnt=%b preempt=%b, expected 0001 0", i, gnt_a, preempt_a);
      end else n_pass++;
    end
    step();
    n_checks++;
    if ({gnt_a, gnt_id_a, preempt_a} !== {4'b0100, 2'd2, 1'b1}) begin
      $display("FAIL preempt_pulse: got gnt=%b id=%0d preempt=%b, expected 0100 id=2 preempt=1",
               gnt_a, gnt_id_a, preempt_a);
    end else n_pass++;
    step();
    n_checks++;
    if ({gnt_a, preempt_a} !== {4'b0100, 1'b0}) begin
      $display("FAIL preempt_one_cycle: got gnt=%b preempt=%b, expected 0100 0", gnt_a, preempt_a);
    end else n_pass++;
    req_a = 4'b0000;
    step();
    req_a = 4'b0001;
    step();
    for (int i = 0; i < 8; i++) begin
      step();
      n_checks++;
      if ({gnt_a, preempt_a} !== {4'b0001, 1'b0}) begin
        $display("FAIL sole_hold_%0d: got gnt=%b preempt=%b, expected 0001 0", i, gnt_a, preempt_a);
      end else n_pass++;
    end
    req_a = 4'b0000;
    step();
  endtask

  task automatic test_release_timeout();
    req_a = 4'b0001;
    step();
    req_a = 4'b0101;
    step();
    step();
    step();
    req_a = 4'b0100;
    step();
    n_checks++;
    if ({gnt_a, gnt_id_a, gnt_valid_a, preempt_a} !== {4'b0100, 2'd2, 1'b1, 1'b0}) begin
      $display("FAIL release_on_timeout: got gnt=%b id=%0d preempt=%b, expected 0100 id=2 preempt=0",
               gnt_a, gnt_id_a, preempt_a);
    end else n_pass++;
  endtask

  task automatic test_reset_mid_grant();
    req_a = 4'b0010;
    step();
    n_checks++;
    if (gnt_a !== 4'b0010) begin
      $display("FAIL pre_reset_owner: got gnt=%b, expected 0010", gnt_a);
    end else n_pass++;
    req_a = 4'b1111;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({gnt_a, gnt_id_a, gnt_valid_a, preempt_a} !== 8'h00) begin
      $display("FAIL async_reset: got %b, expected 00000000",
               {gnt_a, gnt_id_a, gnt_valid_a, preempt_a});
    end else n_pass++;
    step();
    step();
    rst_n = 1'b1;
    step();
    n_checks++;
    if ({gnt_a, gnt_id_a, gnt_valid_a, preempt_a} !== {4'b1000, 2'd3, 1'b1, 1'b0}) begin
      $display("FAIL post_reset_grant: got %b, expected 10001110",
               {gnt_a, gnt_id_a, gnt_valid_a, preempt_a});
    end else n_pass++;
    req_a = 4'b0111;
    step();
    n_checks++;
    if ({gnt_a, gnt_id_a} !== {4'b0100, 2'd2}) begin
      $display("FAIL post_reset_order: got gnt=%b id=%0d, expected 0100 id=2", gnt_a, gnt_id_a);
    end else n_pass++;
    req_a = 4'b0000;
    step();
  endtask

  initial begin
    test_reset();
    test_rr_rotation();
    test_fixed_priority();
    test_timeout();
    test_release_timeout();
    test_reset_mid_grant();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
